// File: rtl/draw_arbiter.sv
// Shares the vga_adapter write port among sprite draw engines.
// One owner at a time, go/done handshake, optional hang timeout.
module draw_arbiter #(
   parameter int NUM_CLIENTS = 4,
   parameter int X_W         = 8,
   parameter int Y_W         = 7,
   parameter int C_W         = 3,
   parameter int RR_MODE     = 1,
   parameter int TIMEOUT     = 0
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [NUM_CLIENTS-1:0]     req,
   input  logic [NUM_CLIENTS-1:0]     done,
   input  logic [NUM_CLIENTS-1:0]     plot_in,
   input  logic [NUM_CLIENTS*X_W-1:0] x_in,
   input  logic [NUM_CLIENTS*Y_W-1:0] y_in,
   input  logic [NUM_CLIENTS*C_W-1:0] colour_in,
   output logic [NUM_CLIENTS-1:0]     grant,
   output logic                       writeEn,
   output logic [X_W-1:0]             x_out,
   output logic [Y_W-1:0]             y_out,
   output logic [C_W-1:0]             colour_out,
   output logic [2:0]                 owner_id,
   output logic                       timeout_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_RELEASE
   } state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
   localparam logic        TO_EN   = (TIMEOUT != 0);

   state_t                 state_q, state_d;
   logic [NUM_CLIENTS-1:0] grant_q, grant_d;
   logic [2:0]             owner_q, owner_d;
   logic [2:0]             rr_ptr_q, rr_ptr_d;
   logic [15:0]            cnt_q, cnt_d;
   logic                   we_q, we_d;
   logic                   tmo_q, tmo_d;
   logic [X_W-1:0]         x_q, x_d;
   logic [Y_W-1:0]         y_q, y_d;
   logic [C_W-1:0]         col_q, col_d;

   logic                   own_plot, own_done;
   logic [X_W-1:0]         own_x;
   logic [Y_W-1:0]         own_y;
   logic [C_W-1:0]         own_col;
   logic [2:0]             lo, hi, win;
   logic                   hit;
   logic [NUM_CLIENTS-1:0] win_oh;

   // Mux the current owner's lane out of the packed client buses.
   always_comb begin
      own_plot = 1'b0;
      own_done = 1'b0;
      own_x    = '0;
      own_y    = '0;
      own_col  = '0;
      for (int j = 0; j < NUM_CLIENTS; j++) begin
         if (owner_q == 3'(j)) begin
            own_plot = plot_in[j];
            own_done = done[j];
            own_x    = x_in[j*X_W +: X_W];
            own_y    = y_in[j*Y_W +: Y_W];
            own_col  = colour_in[j*C_W +: C_W];
         end
      end
   end

   // lo: lowest requester; hi: lowest requester at or above rr_ptr.
   always_comb begin
      lo  = 3'd0;
      hi  = 3'd0;
      hit = 1'b0;
      for (int j = NUM_CLIENTS - 1; j >= 0; j--) begin
         if (req[j]) lo = 3'(j);
         if (req[j] && (3'(j) >= rr_ptr_q)) begin
            hi  = 3'(j);
            hit = 1'b1;
         end
      end
      win = ((RR_MODE != 0) && hit) ? hi : lo;
      for (int j = 0; j < NUM_CLIENTS; j++) begin
         win_oh[j] = (win == 3'(j));
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      tmo_d    = 1'b0;
      we_d     = (state_q == S_GRANT) && own_plot;
      x_d      = we_d ? own_x   : x_q;
      y_d      = we_d ? own_y   : y_q;
      col_d    = we_d ? own_col : col_q;
      unique case (state_q)
         S_IDLE: begin
            if (|req) begin
               owner_d = win;
               grant_d = win_oh;
               cnt_d   = 16'd0;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            cnt_d = cnt_q + 16'd1;
            if (own_done) begin
               grant_d = '0;
               state_d = S_RELEASE;
            end else if (TO_EN && (cnt_q == TO_LAST)) begin
               grant_d = '0;
               tmo_d   = 1'b1;
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            grant_d  = '0;
            cnt_d    = 16'd0;
            rr_ptr_d = (owner_q == 3'(NUM_CLIENTS - 1)) ? 3'd0
                                                         : owner_q + 3'd1;
            state_d  = S_IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         grant_q  <= '0;
         owner_q  <= 3'd0;
         rr_ptr_q <= 3'd0;
         cnt_q    <= 16'd0;
         we_q     <= 1'b0;
         tmo_q    <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         col_q    <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         tmo_q    <= tmo_d;
         x_q      <= x_d;
         y_q      <= y_d;
         col_q    <= col_d;
      end
   end

   assign grant       = grant_q;
   assign writeEn     = we_q;
   assign x_out       = x_q;
   assign y_out       = y_q;
   assign colour_out  = col_q;
   assign owner_id    = owner_q;
   assign timeout_err = tmo_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Randomized bench for draw_arbiter against a cycle-level reference model.
// Two instances: round-robin with timeout 16, fixed priority without timeout.
module tb_draw_arbiter;
   localparam int N  = 4;
   localparam int XW = 8;
   localparam int YW = 7;
   localparam int CW = 3;

   logic          clk    = 1'b0;
   logic          resetn = 1'b1;
   logic [N-1:0]  req, done, plot;
   logic [N*XW-1:0] x_in;
   logic [N*YW-1:0] y_in;
   logic [N*CW-1:0] c_in;

   logic [N-1:0]  gA, gB;
   logic          weA, weB, toA, toB;
   logic [XW-1:0] xA, xB;
   logic [YW-1:0] yA, yB;
   logic [CW-1:0] cA, cB;
   logic [2:0]    oA, oB;

   always #5 clk = ~clk;

   draw_arbiter #(
      .NUM_CLIENTS(N), .X_W(XW), .Y_W(YW), .C_W(CW),
      .RR_MODE(1), .TIMEOUT(16)
   ) dut_a (
      .clk(clk), .resetn(resetn), .req(req), .done(done),
      .plot_in(plot), .x_in(x_in), .y_in(y_in), .colour_in(c_in),
      .grant(gA), .writeEn(weA), .x_out(xA), .y_out(yA),
      .colour_out(cA), .owner_id(oA), .timeout_err(toA)
   );

   draw_arbiter #(
      .NUM_CLIENTS(N), .X_W(XW), .Y_W(YW), .C_W(CW),
      .RR_MODE(0), .TIMEOUT(0)
   ) dut_b (
      .clk(clk), .resetn(resetn), .req(req), .done(done),
      .plot_in(plot), .x_in(x_in), .y_in(y_in), .colour_in(c_in),
      .grant(gB), .writeEn(weB), .x_out(xB), .y_out(yB),
      .colour_out(cB), .owner_id(oB), .timeout_err(toB)
   );

   typedef struct {
      bit busy;
      bit rel;
      bit we;
      bit tmo;
      int owner;
      int held;
      int ptr;
      int x;
      int y;
      int c;
   } model_t;

   model_t ma, mb;
   int total = 0;
   int bad   = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic model_t mreset();
      model_t m;
      m.busy = 0; m.rel = 0; m.we = 0; m.tmo = 0;
      m.owner = 0; m.held = 0; m.ptr = 0;
      m.x = 0; m.y = 0; m.c = 0;
      return m;
   endfunction

   // One clock of the arbiter, described as owned / cooling-down / free.
   function automatic model_t step(model_t m, bit rr, int to);
      model_t n = m;
      n.tmo = 0;
      n.we  = m.busy && plot[m.owner];
      if (n.we) begin
         n.x = x_in[m.owner*XW +: XW];
         n.y = y_in[m.owner*YW +: YW];
         n.c = c_in[m.owner*CW +: CW];
      end
      if (m.busy) begin
         n.held = m.held + 1;
         if (done[m.owner]) begin
            n.busy = 0; n.rel = 1;
         end else if (to != 0 && n.held == to) begin
            n.busy = 0; n.rel = 1; n.tmo = 1;
         end
      end else if (m.rel) begin
         n.rel = 0;
         n.ptr = (m.owner + 1) % N;
      end else if (req != 0) begin
         n.busy = 1;
         n.held = 0;
         for (int k = N - 1; k >= 0; k--) begin
            int c = rr ? (m.ptr + k) % N : k;
            if (req[c]) n.owner = c;
         end
      end
      return n;
   endfunction

   function automatic logic [31:0] onehot(model_t m);
      return m.busy ? (32'd1 << m.owner) : 32'd0;
   endfunction

   task automatic check_all();
      chk("grantA", gA, onehot(ma));
      chk("weA", weA, ma.we);
      chk("xA", xA, ma.x);
      chk("yA", yA, ma.y);
      chk("cA", cA, ma.c);
      chk("ownerA", oA, ma.owner);
      chk("toA", toA, ma.tmo);
      chk("grantB", gB, onehot(mb));
      chk("weB", weB, mb.we);
      chk("xB", xB, mb.x);
      chk("yB", yB, mb.y);
      chk("cB", cB, mb.c);
      chk("ownerB", oB, mb.owner);
      chk("toB", toB, mb.tmo);
   endtask

   task automatic cycle();
      @(posedge clk);
      ma = step(ma, 1'b1, 16);
      mb = step(mb, 1'b0, 0);
      #1;
      check_all();
   endtask

   task automatic zero_in();
      req = '0; done = '0; plot = '0;
      x_in = '0; y_in = '0; c_in = '0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      #1;
      chk("rst_grantA", gA, 0);
      chk("rst_weA", weA, 0);
      chk("rst_grantB", gB, 0);
      chk("rst_weB", weB, 0);
      ma = mreset();
      mb = mreset();
      zero_in();
      @(posedge clk);
      #1;
      resetn = 1'b1;
      check_all();
   endtask

   initial begin
      int ta, tb;
      bit prev_a, prev_b;
      int qa[$];
      int qb[$];
      int exp_rr[5] = '{0, 1, 2, 3, 0};

      zero_in();
      #2;
      do_reset();

      // single client with a pixel write
      req = 4'b0100;
      cycle();
      cycle();
      chk("single_grant", gA, 4'b0100);
      plot = 4'b0100;
      x_in[2*XW +: XW] = 8'd80;
      y_in[2*YW +: YW] = 7'd60;
      cycle();
      chk("single_we", weA, 1);
      chk("single_x", xA, 80);
      chk("single_y", yA, 60);
      plot = '0;
      done = 4'b0100;
      cycle();
      done = '0;
      req  = '0;
      chk("single_rel", gA, 0);
      cycle();
      chk("single_gap", gA, 0);

      // reset while a grant is held
      req = 4'b0010;
      cycle();
      cycle();
      do_reset();

      // everyone requesting, each owner finishes on its third cycle
      req = 4'b1111;
      prev_a = 0;
      prev_b = 0;
      for (int i = 0; i < 60; i++) begin
         done = '0;
         if (ma.busy && ma.held == 2) done[ma.owner] = 1'b1;
         if (mb.busy && mb.held == 2) done[mb.owner] = 1'b1;
         cycle();
         if (gA != 0 && !prev_a) qa.push_back(int'(oA));
         if (gB != 0 && !prev_b) qb.push_back(int'(oB));
         prev_a = (gA != 0);
         prev_b = (gB != 0);
      end
      chk("rr_count", qa.size() >= 5, 1);
      chk("fp_count", qb.size() >= 3, 1);
      for (int i = 0; i < 5; i++)
         if (i < qa.size()) chk("rr_order", qa[i], exp_rr[i]);
      for (int i = 0; i < 3; i++)
         if (i < qb.size()) chk("fp_order", qb[i], 0);

      // non-owner plot and done are ignored
      do_reset();
      req = 4'b0010;
      cycle();
      cycle();
      plot = 4'b1000;
      done = 4'b1000;
      x_in[3*XW +: XW] = 8'd159;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("iso_we", weA, 0);
         chk("iso_grant", gA, 4'b0010);
      end
      zero_in();

      // hung owner is forced off, the other requester follows
      do_reset();
      req = 4'b1010;
      ta = 0;
      tb = 0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         ta += int'(toA);
         tb += int'(toB);
      end
      chk("to_pulses", ta, 2);
      chk("to_none_b", tb, 0);

      // done on the final allowed cycle wins over timeout
      do_reset();
      req = 4'b0001;
      ta = 0;
      for (int i = 0; i < 40; i++) begin
         done = '0;
         if (ma.busy && ma.held == 15) done[ma.owner] = 1'b1;
         cycle();
         ta += int'(toA);
      end
      chk("done_vs_to", ta, 0);

      // random traffic with occasional resets
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         req  = N'($urandom);
         done = N'($urandom & $urandom & $urandom);
         plot = N'($urandom);
         x_in = ($urandom);
         y_in = N*YW'($urandom);
         c_in = N*CW'($urandom);
         if (i % 500 == 250) do_reset();
         else cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
